// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: on-chip error statistics for an 8x8 approximate
// multiplier. Samples (a, b, approximate product) are accepted through a
// valid/ready handshake. The exact product is registered in stage 1. Stage 2
// folds the signed error distance into the window accumulators.
// The window closes after N_SAMPLES accepts. The results then stay frozen
// until the next start.
module approx_mul_err_monitor #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 10000,
  parameter int CNT_W     = 32,
  parameter int SUM_W     = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [2*W-1:0]       in_apprx,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [SUM_W:0]       sum_ed,
  output logic [SUM_W-1:0]     sum_ed_abs,
  output logic [2*W-1:0]       max_ed
);

  localparam int PW = 2 * W;
  localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [SUM_W:0]    sum_ed_q, sum_ed_d;
  logic [SUM_W-1:0]  sum_ed_abs_q, sum_ed_abs_d;
  logic [PW-1:0]     max_ed_q, max_ed_d;
  logic              s1_vld_q, s1_vld_d;
  logic [PW-1:0]     s1_exact_q, s1_exact_d;
  logic [PW-1:0]     s1_apprx_q, s1_apprx_d;

  logic              accept;
  logic              clear;
  logic [PW:0]       d;
  logic [PW:0]       d_neg;
  logic [PW-1:0]     d_abs;

  // Handshake and status decode; all come straight from registered state.
  assign in_ready = (state_q == S_RUN) && (sample_count_q < N_LIM);
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign accept   = in_valid && in_ready;
  // A start only opens a window from IDLE or DONE; elsewhere it is ignored.
  assign clear    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_ed       = sum_ed_q;
  assign sum_ed_abs   = sum_ed_abs_q;
  assign max_ed       = max_ed_q;

  // Stage 2 error distance: one extra bit so apprx > exact goes negative.
  always_comb begin
    d     = {1'b0, s1_exact_q} - {1'b0, s1_apprx_q};
    d_neg = -d;
    d_abs = d[PW] ? d_neg[PW-1:0] : d[PW-1:0];
  end

  // Stage 1 capture, accumulator update and sample counting.
  always_comb begin
    s1_vld_d       = accept;
    s1_exact_d     = s1_exact_q;
    s1_apprx_d     = s1_apprx_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_ed_d       = sum_ed_q;
    sum_ed_abs_d   = sum_ed_abs_q;
    max_ed_d       = max_ed_q;
    if (accept) begin
      s1_exact_d     = PW'(in_a) * PW'(in_b);
      s1_apprx_d     = in_apprx;
      sample_count_d = sample_count_q + CNT_W'(1);
    end
    if (clear) begin
      // accept is 0 here: in_ready is low outside RUN.
      s1_vld_d       = 1'b0;
      sample_count_d = '0;
      err_count_d    = '0;
      sum_ed_d       = '0;
      sum_ed_abs_d   = '0;
      max_ed_d       = '0;
    end else if (s1_vld_q) begin
      if (d != '0) err_count_d = err_count_q + CNT_W'(1);
      sum_ed_d     = sum_ed_q + {{(SUM_W - PW){d[PW]}}, d};
      sum_ed_abs_d = sum_ed_abs_q + SUM_W'(d_abs);
      if (d_abs > max_ed_q) max_ed_d = d_abs;
    end
  end

  // Window FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && (sample_count_q == N_LIM - CNT_W'(1))) state_d = S_DRAIN;
      // Leave DRAIN on the edge that retires the last stage-1 sample.
      // That sample's update and done then become visible together.
      S_DRAIN: if (!s1_vld_d) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State, pipeline and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_ed_q       <= '0;
      sum_ed_abs_q   <= '0;
      max_ed_q       <= '0;
      s1_vld_q       <= 1'b0;
      s1_exact_q     <= '0;
      s1_apprx_q     <= '0;
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_ed_q       <= sum_ed_d;
      sum_ed_abs_q   <= sum_ed_abs_d;
      max_ed_q       <= max_ed_d;
      s1_vld_q       <= s1_vld_d;
      s1_exact_q     <= s1_exact_d;
      s1_apprx_q     <= s1_apprx_d;
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed bench for approx_mul_err_monitor with a 4-sample window.
// Stimulus pushes the hand-computed window totals into a queue. A monitor
// pops one entry each time done rises and compares the frozen outputs.
module tb_approx_mul_err_monitor;

  localparam int W = 8, N = 4, CNT_W = 32, SUM_W = 40;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic [W-1:0]        in_a = '0;
  logic [W-1:0]        in_b = '0;
  logic [2*W-1:0]      in_apprx = '0;
  logic                in_ready, busy, done;
  logic [CNT_W-1:0]    sample_count, err_count;
  logic [SUM_W:0]      sum_ed;
  logic [SUM_W-1:0]    sum_ed_abs;
  logic [2*W-1:0]      max_ed;

  approx_mul_err_monitor #(.W(W), .N_SAMPLES(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_apprx(in_apprx),
    .in_ready(in_ready), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count),
    .sum_ed(sum_ed), .sum_ed_abs(sum_ed_abs), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sc; longint ec; longint sum; longint sabs; longint mx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input longint sc, input longint ec, input longint sum,
                          input longint sabs, input longint mx);
    exp_t e;
    e.sc = sc; e.ec = ec; e.sum = sum; e.sabs = sabs; e.mx = mx;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a sample and hold it until it is accepted. in_valid is left
  // high so callers can run back-to-back or hold valid past the window.
  task automatic send(input int a, input int b, input int p);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = W'(a); in_b = W'(b); in_apprx = (2*W)'(p);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    if (!done) chk("done_timeout", 0, 1);
    tick();
  endtask

  // Reference window: (12,12,140) (100,3,310) (255,255,64000) (1,1,1)
  // d = +4, -10, +1025, 0.
  task automatic push_ref4();
    push_exp(4, 3, 1019, 1039, 1025);
  endtask

  // Scoreboard monitor: compare frozen totals whenever done rises.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        chk("busy_low_at_done", busy, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sample_count", sample_count, e.sc);
          chk("err_count", err_count, e.ec);
          chk("sum_ed", longint'($signed(sum_ed)), e.sum);
          chk("sum_ed_abs", sum_ed_abs, e.sabs);
          chk("max_ed", max_ed, e.mx);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_sum_ed_abs", sum_ed_abs, 0);
    rst = 1'b0;
    tick();

    // T1: exact samples; start coincident with valid is not accepted
    push_exp(4, 0, 0, 0, 0);
    in_valid = 1'b1; in_a = 8'd10; in_b = 8'd20; in_apprx = 16'd200;
    pulse_start();
    chk("t1_start_no_accept", sample_count, 0);
    chk("t1_busy_after_start", busy, 1);
    send(10, 20, 200);
    send(255, 255, 65025);
    send(0, 7, 0);
    send(3, 3, 9);
    in_valid = 1'b0;
    wait_done();

    // T2: mixed errors; done exactly two cycles after the final accept
    push_ref4();
    pulse_start();
    chk("t2_cleared_by_start", sample_count, 0);
    send(12, 12, 140);
    send(100, 3, 310);
    send(255, 255, 64000);
    send(1, 1, 1);
    in_valid = 1'b0;
    chk("t2_done_1cyc", done, 0);
    chk("t2_busy_drain", busy, 1);
    chk("t2_in_ready_drain", in_ready, 0);
    tick();
    chk("t2_done_2cyc", done, 1);
    wait_done();

    // T3: valid held high past the window; the 5th sample never counts
    push_ref4();
    pulse_start();
    send(12, 12, 140);
    send(100, 3, 310);
    send(255, 255, 64000);
    send(1, 1, 1);
    in_a = 8'd9; in_b = 8'd9; in_apprx = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_done();

    // T4: bubbles 1,0,0,1,1,0,1 give the gap-free totals
    push_ref4();
    pulse_start();
    send(12, 12, 140);
    in_valid = 1'b0; tick(); tick();
    send(100, 3, 310);
    send(255, 255, 64000);
    in_valid = 1'b0; tick();
    send(1, 1, 1);
    in_valid = 1'b0;
    wait_done();

    // T5: reset after two accepts discards everything at once
    pulse_start();
    send(255, 255, 0);
    send(255, 255, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_sample_count", sample_count, 0);
    chk("t5_rst_err_count", err_count, 0);
    chk("t5_rst_sum_ed_abs", sum_ed_abs, 0);
    chk("t5_rst_max_ed", max_ed, 0);
    chk("t5_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    push_ref4();
    pulse_start();
    send(12, 12, 140);
    send(100, 3, 310);
    send(255, 255, 64000);
    send(1, 1, 1);
    in_valid = 1'b0;
    wait_done();

    // T6: start in DONE clears on the edge; start in RUN is ignored
    pulse_start();
    chk("t6_sample_count_clr", sample_count, 0);
    chk("t6_err_count_clr", err_count, 0);
    chk("t6_sum_ed_clr", longint'($signed(sum_ed)), 0);
    chk("t6_sum_ed_abs_clr", sum_ed_abs, 0);
    chk("t6_max_ed_clr", max_ed, 0);
    chk("t6_done_clr", done, 0);
    chk("t6_busy_set", busy, 1);
    // d = +4, 0, -10, -1
    push_exp(4, 3, -7, 15, 10);
    send(12, 12, 140);
    send(1, 1, 1);
    in_valid = 1'b0;
    pulse_start();
    chk("t6_start_in_run_count", sample_count, 2);
    chk("t6_start_in_run_err", err_count, 1);
    send(100, 3, 310);
    send(2, 2, 5);
    in_valid = 1'b0;
    wait_done();

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
